read_line_buf: RTL and testbench
================================

// Module: read_line_buf
// PURPOSE
//  Read-side line buffer for the compute-unit load path; counterpart of the store write-merge path.
//  Takes 32-bit load requests and serves them from small fully-associative 16-byte lines.
//  On a miss it fills a line with four 32-bit memory reads, then returns the requested word.
//  Sits between the LSU load port and the 32-bit memory interface.
// PARAMETERS
//  ENTRIES  4  number of 16-byte lines (power of 2, >=2)
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-high reset
//  req_valid      in   1   load request
//  req_addr       in   32  byte address; [1:0] ignored (word access)
//  req_ready      out  1   request accepted when valid&ready
//  rsp_valid      out  1   load data valid
//  rsp_data       out  32  load data
//  rsp_ready      in   1   consumer accepts rsp
//  mem_req_valid  out  1   memory word read request
//  mem_req_addr   out  32  word-aligned read address
//  mem_req_ready  in   1   memory accepts request
//  mem_rsp_valid  in   1   memory read data valid (no backpressure)
//  mem_rsp_data   in   32  memory read data
//  inval          in   1   invalidate all lines (MEMBAR/abort)
//  snoop_valid    in   1   store observed on store path
//  snoop_addr     in   32  store address
//  busy           out  1   state != ST_IDLE or rsp_valid
// BEHAVIOUR
//  Reset: all lines invalid; state ST_IDLE; rr_ptr=0; rsp_valid=0, rsp_data=0, mem_req_valid=0,
//   mem_req_addr=0, req_ready=0 in the reset cycle.
//  Entry: valid, tag=addr[31:4], data[127:0]. Hit = valid && tag==req_addr[31:4] (at most one).
//  req_ready = (state==ST_IDLE) && !rsp_valid && !inval.
//  States:
//   ST_IDLE: on accept: hit -> rsp_valid=1 next cycle, rsp_data=data[addr[3:2]*32+:32] (latency 1);
//    miss -> latch addr, pick victim (lowest invalid entry, else rr_ptr), fill_word=0, go ST_FILL_REQ.
//   ST_FILL_REQ: mem_req_valid=1, mem_req_addr={tag,fill_word,2'b00}; on mem_req_ready -> ST_FILL_WAIT.
//   ST_FILL_WAIT: on mem_rsp_valid store word into fill buffer; fill_word==3 -> ST_RESP, else
//    fill_word++ -> ST_FILL_REQ. One outstanding read; fill order strictly word 0,1,2,3.
//   ST_RESP: install line into victim (valid=1) unless fill_poison; advance rr_ptr by 1 (wraps)
//    only if the victim was chosen via rr_ptr; drive rsp_valid=1 with requested word next cycle; -> ST_IDLE.
//  rsp_valid holds with stable rsp_data until rsp_ready; clears the cycle after the handshake.
//  mem_rsp_valid outside ST_FILL_WAIT is ignored (e.g. stale response after reset).
//  inval: clears all valid bits the same cycle; also sets fill_poison if a fill is in flight.
//   The fill is never aborted (memory reads outstanding) and the response is still returned, but the
//   line is not installed. inval has priority over a same-cycle install.
//  Simultaneous inval and req_valid: request not accepted (req_ready=0).
//  fill_poison clears on entering ST_IDLE.
//  Load-after-store ordering: the upstream agent drains the write-merge path before dependent loads;
//   this block does not forward store data.
// CONFIGURATION
//  RLB_STORE_SNOOP_EN defined: snoop_valid clears any valid line with tag==snoop_addr[31:4] that
//   same cycle. A match with the in-flight fill tag sets fill_poison. Snoop and install of the same
//   tag in one cycle resolve to not installed. Snoop matching a same-cycle hit: the hit still
//   returns old data, and the line is cleared.
//  Undefined: snoop_valid/snoop_addr ignored; only inval removes lines.
// STRUCTURE
//  Package rlb_pkg: state_t enum {ST_IDLE, ST_FILL_REQ, ST_FILL_WAIT, ST_RESP}, rlb_entry_t
//   (valid, tag[31:4], data[127:0]), LINE_BYTES=16, WORDS_PER_LINE=4.
//  Sub-module rlb_tag_match: combinational hit/hit_idx/free_found/free_idx over ENTRIES tags;
//   instanced twice (request lookup, snoop lookup). All sequencing stays in read_line_buf.
// TESTING
//  1 Cold miss 0x100, memory returns 0xA0..0xA3 for 0x100..0x10C -> 4 mem reads in order,
//    rsp_data=0xA0; then load 0x108 -> hit, rsp_valid 1 cycle after accept, data 0xA2, no mem_req.
//  2 Fill lines 0x000,0x010,0x020,0x030, then load 0x040 -> victim entry 0 (rr_ptr=0),
//    rr_ptr=1; reload 0x000 -> miss.
//  3 inval asserted during ST_FILL_WAIT of 0x200 -> fill completes, rsp returned, next load 0x200
//    misses; req_ready=0 in the inval cycle.
//  4 rsp_ready held low 5 cycles after a hit -> rsp_valid/rsp_data stable, req_ready=0, no new accept.
//  5 (RLB_STORE_SNOOP_EN) hit line 0x300, snoop 0x304 -> next load 0x300 misses; snoop 0x500
//    during fill of 0x500 -> not installed. Without the macro -> 0x300 still hits.
//  6 rst asserted in ST_FILL_WAIT, late mem_rsp_valid next cycle -> ignored; all lines invalid,
//    busy=0, all outputs at reset values.

Source files
------------

// File: rtl/rlb_pkg.sv
// Shared types and constants for the read line buffer.
package rlb_pkg;

    localparam int LINE_BYTES     = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int TAG_W          = 28;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL_REQ,
        ST_FILL_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [31:4]      tag;
        logic [127:0]     data;
    } rlb_entry_t;

    // Select one 32-bit word out of a 16-byte line.
    function automatic logic [31:0] line_word(input logic [127:0] line, input logic [1:0] idx);
        return line[{idx, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/rlb_tag_match.sv
// Combinational lookup over all line tags: matching entry plus lowest free entry.
module rlb_tag_match
    import rlb_pkg::*;
#(
    parameter int ENTRIES = 4,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0]            valid,
    input  logic [ENTRIES-1:0][TAG_W-1:0] tags,
    input  logic [TAG_W-1:0]              lookup_tag,
    output logic                          hit,
    output logic [IDX_W-1:0]              hit_idx,
    output logic                          free_found,
    output logic [IDX_W-1:0]              free_idx
);

    // Walk downwards so the lowest free index is the one left standing.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && (tags[i] == lookup_tag)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/read_line_buf.sv
// Read-side line buffer: serves 32-bit loads from fully-associative 16-byte lines.
// Optional store snooping is enabled with the RLB_STORE_SNOOP_EN macro.
module read_line_buf
    import rlb_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    input  logic        rsp_ready,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        inval,
    input  logic        snoop_valid,
    input  logic [31:0] snoop_addr,
    output logic        busy
);

    localparam int IDX_W = $clog2(ENTRIES);

    // valid/ready: a transfer happens on a rising clk edge where both are high;
    // a raised valid holds its payload stable until that edge.

    rlb_entry_t                            lines [ENTRIES];
    state_t                                state;
    logic [IDX_W-1:0]                      rr_ptr;
    logic [IDX_W-1:0]                      victim;
    logic                                  victim_rr;
    logic [31:4]                           fill_tag;
    logic [1:0]                            fill_word;
    logic [1:0]                            req_word;
    logic [WORDS_PER_LINE-1:0][31:0]       fill_buf;
    logic                                  fill_poison;

    logic [ENTRIES-1:0]                    valid_vec;
    logic [ENTRIES-1:0][TAG_W-1:0]         tag_vec;
    logic                                  req_hit;
    logic [IDX_W-1:0]                      req_hit_idx;
    logic                                  req_free_found;
    logic [IDX_W-1:0]                      req_free_idx;
    logic                                  accept;
    logic                                  fill_active;

    logic                                  snoop_kill;
    logic [IDX_W-1:0]                      snoop_idx;
    logic                                  snoop_fill_hit;
    logic                                  snoop_req_hit;

    always_comb begin
        valid_vec = '0;
        tag_vec   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            valid_vec[i] = lines[i].valid;
            tag_vec[i]   = lines[i].tag;
        end
    end

    rlb_tag_match #(.ENTRIES(ENTRIES)) u_req_match (
        .valid      (valid_vec),
        .tags       (tag_vec),
        .lookup_tag (req_addr[31:4]),
        .hit        (req_hit),
        .hit_idx    (req_hit_idx),
        .free_found (req_free_found),
        .free_idx   (req_free_idx)
    );

`ifdef RLB_STORE_SNOOP_EN
    logic                 snp_hit;
    logic                 unused_snp_free_found;
    logic [IDX_W-1:0]     unused_snp_free_idx;
    logic [5:0]           unused_low_bits;

    rlb_tag_match #(.ENTRIES(ENTRIES)) u_snoop_match (
        .valid      (valid_vec),
        .tags       (tag_vec),
        .lookup_tag (snoop_addr[31:4]),
        .hit        (snp_hit),
        .hit_idx    (snoop_idx),
        .free_found (unused_snp_free_found),
        .free_idx   (unused_snp_free_idx)
    );

    assign snoop_kill      = snoop_valid && snp_hit;
    assign snoop_fill_hit  = snoop_valid && (snoop_addr[31:4] == fill_tag);
    assign snoop_req_hit   = snoop_valid && (snoop_addr[31:4] == req_addr[31:4]);
    assign unused_low_bits = {req_addr[1:0], snoop_addr[3:0]};
`else
    logic [34:0]          unused_snoop_bits;

    assign snoop_kill        = 1'b0;
    assign snoop_idx         = '0;
    assign snoop_fill_hit    = 1'b0;
    assign snoop_req_hit     = 1'b0;
    assign unused_snoop_bits = {snoop_valid, snoop_addr, req_addr[1:0]};
`endif

    assign req_ready   = !rst && (state == ST_IDLE) && !rsp_valid && !inval;
    assign accept      = req_valid && req_ready;
    assign busy        = (state != ST_IDLE) || rsp_valid;
    assign fill_active = (state == ST_FILL_REQ) || (state == ST_FILL_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            victim        <= '0;
            victim_rr     <= 1'b0;
            fill_tag      <= '0;
            fill_word     <= '0;
            req_word      <= '0;
            fill_poison   <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                lines[i].valid <= 1'b0;
            end
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_hit) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= line_word(lines[req_hit_idx].data, req_addr[3:2]);
                        end else begin
                            fill_tag      <= req_addr[31:4];
                            req_word      <= req_addr[3:2];
                            victim        <= req_free_found ? req_free_idx : rr_ptr;
                            victim_rr     <= !req_free_found;
                            fill_word     <= '0;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {req_addr[31:4], 4'b0000};
                            state         <= ST_FILL_REQ;
                            // A store to this line racing the accept makes the fill stale.
                            if (snoop_req_hit) begin
                                fill_poison <= 1'b1;
                            end
                        end
                    end
                end

                ST_FILL_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_FILL_WAIT;
                    end
                end

                ST_FILL_WAIT: begin
                    if (mem_rsp_valid) begin
                        fill_buf[fill_word] <= mem_rsp_data;
                        if (fill_word == 2'd3) begin
                            state <= ST_RESP;
                        end else begin
                            fill_word     <= fill_word + 2'd1;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {fill_tag, fill_word + 2'd1, 2'b00};
                            state         <= ST_FILL_REQ;
                        end
                    end
                end

                ST_RESP: begin
                    if (!fill_poison && !inval && !snoop_fill_hit) begin
                        lines[victim].valid <= 1'b1;
                        lines[victim].tag   <= fill_tag;
                        lines[victim].data  <= fill_buf;
                    end
                    if (victim_rr) begin
                        rr_ptr <= rr_ptr + IDX_W'(1);
                    end
                    rsp_valid   <= 1'b1;
                    rsp_data    <= fill_buf[req_word];
                    fill_poison <= 1'b0;
                    state       <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase

            // Placed after the case so invalidation wins over a same-cycle install.
            if (inval) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    lines[i].valid <= 1'b0;
                end
                if (fill_active) begin
                    fill_poison <= 1'b1;
                end
            end

            if (snoop_kill) begin
                lines[snoop_idx].valid <= 1'b0;
            end
            if (snoop_fill_hit && fill_active) begin
                fill_poison <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_read_line_buf.sv
// Self-checking bench for read_line_buf with a line-level reference model and a memory responder.
module tb_read_line_buf;

    localparam int ENTRIES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_ready;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inval;
    logic        snoop_valid;
    logic [31:0] snoop_addr;
    logic        busy;

    always #5 clk = ~clk;

    read_line_buf #(.ENTRIES(ENTRIES)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_ready     (rsp_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inval         (inval),
        .snoop_valid   (snoop_valid),
        .snoop_addr    (snoop_addr),
        .busy          (busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_log[$];
    bit          mem_auto = 1'b1;
    bit          late_rsp = 1'b0;

    bit          m_valid[ENTRIES];
    logic [27:0] m_tag[ENTRIES];
    int          m_rr;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a >= 32'h100 && a <= 32'h10C) return 32'hA0 + ((a - 32'h100) >> 2);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_find(input logic [27:0] tag);
        for (int i = 0; i < ENTRIES; i++) if (m_valid[i] && m_tag[i] == tag) return i;
        return -1;
    endfunction

    function automatic int model_free();
        for (int i = 0; i < ENTRIES; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    endtask

    // Memory side: log every accepted read, answer it 0..2 cycles later, strictly in order.
    initial begin
        bit          pending = 1'b0;
        int          delay = 0;
        logic [31:0] paddr = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            if (!rst && mem_req_valid && mem_req_ready) begin
                mem_log.push_back(mem_req_addr);
                if (mem_auto) begin
                    pending = 1'b1;
                    delay   = $urandom_range(0, 2);
                    paddr   = mem_req_addr;
                end
            end
            if (!mem_auto) pending = 1'b0;
            @(negedge clk);
            #2;
            mem_req_ready = ($urandom_range(0, 3) != 0);
            mem_rsp_valid = 1'b0;
            if (late_rsp) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'hDEAD_BEEF;
            end else if (pending) begin
                if (delay == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_val(paddr);
                    pending       = 1'b0;
                end else begin
                    delay--;
                end
            end
        end
    end

    // inj: 0 none, 1 inval during the fill, 2 snoop of the same line during the fill.
    task automatic do_load(input logic [31:0] addr, input int stall, input int inj);
        int          cyc;
        bit          exp_hit;
        bit          poison;
        bit          injected;
        int          vict;
        bit          vict_rr;
        logic [31:0] held;
        exp_hit = (model_find(addr[31:4]) >= 0);
        vict    = model_free();
        vict_rr = (vict < 0);
        if (vict_rr) vict = m_rr;
        exp_q.push_back(mem_val({addr[31:2], 2'b00}));
        mem_log.delete();
        poison   = 1'b0;
        injected = 1'b0;

        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("req_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);

        if (exp_hit) begin
            check("hit_latency", 32'(rsp_valid), 32'd1);
        end else begin
            cyc = 0;
            while (!rsp_valid && cyc < 300) begin
                if (inj != 0 && !injected && mem_log.size() == 2) begin
                    if (inj == 1) begin
                        inval = 1'b1;
                        model_clear();
                        poison = 1'b1;
                    end else begin
                        snoop_valid = 1'b1;
                        snoop_addr  = addr;
`ifdef RLB_STORE_SNOOP_EN
                        poison = 1'b1;
`endif
                    end
                    #1;
                    check("req_ready_during_inject", 32'(req_ready), 32'd0);
                    injected = 1'b1;
                end
                @(negedge clk);
                inval       = 1'b0;
                snoop_valid = 1'b0;
                cyc++;
            end
            check("miss_rsp", 32'(rsp_valid), 32'd1);
        end

        held = rsp_data;
        for (int k = 0; k < stall; k++) begin
            req_valid = 1'b1;
            req_addr  = 32'h7F0;
            #1;
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_data", rsp_data, held);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check("rsp_data", rsp_data, exp_q.pop_front());
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_clear", 32'(rsp_valid), 32'd0);

        check("mem_read_count", 32'(mem_log.size()), exp_hit ? 32'd0 : 32'd4);
        if (!exp_hit && mem_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("mem_read_addr", mem_log[i], {addr[31:4], 4'b0000} + 32'(4 * i));
            end
        end

        if (!exp_hit) begin
            if (!poison) begin
                m_valid[vict] = 1'b1;
                m_tag[vict]   = addr[31:4];
            end
            if (vict_rr) m_rr = (m_rr + 1) % ENTRIES;
        end
    endtask

    task automatic idle_inval();
        mem_log.delete();
        @(negedge clk);
        inval     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h040;
        #1;
        check("req_ready_inval_idle", 32'(req_ready), 32'd0);
        @(negedge clk);
        inval     = 1'b0;
        req_valid = 1'b0;
        model_clear();
        @(negedge clk);
        check("inval_no_accept_mem", 32'(mem_log.size()), 32'd0);
        check("inval_no_accept_busy", 32'(busy), 32'd0);
    endtask

    task automatic snoop_pulse(input logic [31:0] addr);
        int idx;
        @(negedge clk);
        snoop_valid = 1'b1;
        snoop_addr  = addr;
        @(negedge clk);
        snoop_valid = 1'b0;
`ifdef RLB_STORE_SNOOP_EN
        idx = model_find(addr[31:4]);
        if (idx >= 0) m_valid[idx] = 1'b0;
`else
        idx = -1;
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        check({tag, "_mem_req_addr"}, mem_req_addr, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_addr    = '0;
        rsp_ready   = 1'b0;
        inval       = 1'b0;
        snoop_valid = 1'b0;
        snoop_addr  = '0;
        model_clear();
        m_rr = 0;

        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // cold miss then hit in the same line
        do_load(32'h100, 0, 0);
        do_load(32'h108, 0, 0);

        // fill all entries, then round-robin replacement
        idle_inval();
        do_load(32'h000, 0, 0);
        do_load(32'h014, 0, 0);
        do_load(32'h028, 0, 0);
        do_load(32'h03C, 0, 0);
        do_load(32'h040, 0, 0);
        do_load(32'h000, 0, 0);
        do_load(32'h010, 0, 0);
        do_load(32'h02C, 0, 0);

        // inval during a fill: response still returned, line not kept
        do_load(32'h200, 0, 1);
        do_load(32'h200, 0, 0);

        // consumer backpressure on a hit
        do_load(32'h204, 5, 0);

        // store snooping
        do_load(32'h300, 0, 0);
        do_load(32'h308, 0, 0);
        snoop_pulse(32'h304);
        do_load(32'h300, 0, 0);
        do_load(32'h500, 0, 2);
        do_load(32'h504, 0, 0);

        // randomized traffic over a small working set
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) idle_inval();
            if ($urandom_range(0, 9) == 0) snoop_pulse(32'h800 + 32'($urandom_range(0, 5)) * 16);
            do_load(32'h800 + 32'($urandom_range(0, 5)) * 16 + 32'($urandom_range(0, 15)),
                    $urandom_range(0, 2), ($urandom_range(0, 9) == 0) ? 1 : 0);
        end

        // reset in the middle of a fill, stale memory response afterwards
        mem_auto = 1'b0;
        mem_log.delete();
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h600;
        #1;
        check("rst_test_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (mem_log.size() < 1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_test_first_read", 32'(mem_log.size()), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_cycle_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        late_rsp = 1'b1;
        check_reset_outputs("rst_mid_fill");
        @(negedge clk);
        late_rsp = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_stale_rsp");
        check("after_stale_req_ready", 32'(req_ready), 32'd1);
        model_clear();
        m_rr     = 0;
        mem_auto = 1'b1;
        repeat (2) @(negedge clk);
        do_load(32'h100, 0, 0);
        do_load(32'h10C, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
